// File: rtl/fadd_arbiter.sv
// fadd_arbiter: shares one pipelined fadd unit among NREQ requesters.
//
// Grant is round-robin and combinational. Operands of the granted requester are
// registered into the adder. A tag shift register (issue stage + LAT adder stages)
// records which requester owns each slot. The result is registered back to that
// requester as a one-cycle strobe.
//
// Optional feature: define FADD_ARB_SUB_EN to honour req_sub_i. The sign of x2 is
// flipped on transfer, so the adder computes x1 - x2. Without the macro, req_sub_i
// is ignored. The port list is the same in both builds.
//
// Ports:
//   clk           clock
//   rstn          synchronous active-low reset
//   req_valid_i   per-requester operand valid
//   req_x1_i      operand 1, requester i at [32*i +: 32]
//   req_x2_i      operand 2, same packing
//   req_sub_i     per-requester subtract request (FADD_ARB_SUB_EN only)
//   req_ready_o   one-hot grant; transfer on req_valid_i[i] & req_ready_o[i]
//   fa_x1_o       registered operand 1 to the fadd
//   fa_x2_o       registered operand 2 to the fadd
//   fa_y_i        fadd result
//   fa_ovf_i      fadd overflow flag
//   resp_valid_o  one-hot result strobe
//   resp_y_o      result, held between responses
//   resp_ovf_o    overflow flag of the result, held between responses
//   busy_o        some accepted request has not yet been returned
module fadd_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ-1:0]    req_valid_i,
  input  logic [NREQ*32-1:0] req_x1_i,
  input  logic [NREQ*32-1:0] req_x2_i,
  input  logic [NREQ-1:0]    req_sub_i,
  output logic [NREQ-1:0]    req_ready_o,
  output logic [31:0]        fa_x1_o,
  output logic [31:0]        fa_x2_o,
  input  logic [31:0]        fa_y_i,
  input  logic               fa_ovf_i,
  output logic [NREQ-1:0]    resp_valid_o,
  output logic [31:0]        resp_y_o,
  output logic               resp_ovf_o,
  output logic               busy_o
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]        ptr_q, ptr_d;
  logic [31:0]          fa_x1_q, fa_x1_d;
  logic [31:0]          fa_x2_q, fa_x2_d;
  logic [LAT:0]         tag_vld_q, tag_vld_d;
  logic [LAT:0][PW-1:0] tag_id_q, tag_id_d;
  logic [NREQ-1:0]      resp_valid_q, resp_valid_d;
  logic [31:0]          resp_y_q, resp_y_d;
  logic                 resp_ovf_q, resp_ovf_d;

  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gnt_idx;
  logic            xfer;
  logic [PW:0]     cand;
  logic [PW-1:0]   idx;
  logic [31:0]     sel_x1, sel_x2;
  logic            sel_sub;

  // Round-robin search starting at ptr_q. One extra bit in cand lets the
  // ptr + k sum wrap without overflowing.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    xfer    = 1'b0;
    cand    = '0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(k);
      if (cand >= (PW+1)'(NREQ)) begin
        cand = cand - (PW+1)'(NREQ);
      end
      idx = cand[PW-1:0];
      if (!xfer && req_valid_i[idx]) begin
        xfer         = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = idx;
      end
    end
  end

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_x1  = '0;
    sel_x2  = '0;
    sel_sub = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_x1  = req_x1_i[32*i +: 32];
        sel_x2  = req_x2_i[32*i +: 32];
        sel_sub = req_sub_i[i];
      end
    end
  end

`ifdef FADD_ARB_SUB_EN
  logic [31:0] x2_eff;
  assign x2_eff = {sel_x2[31] ^ sel_sub, sel_x2[30:0]};
`else
  logic [31:0] x2_eff;
  logic        unused_sub;
  assign x2_eff     = sel_x2;
  assign unused_sub = sel_sub;
`endif

  always_comb begin
    ptr_d   = ptr_q;
    fa_x1_d = fa_x1_q;
    fa_x2_d = fa_x2_q;
    if (xfer) begin
      ptr_d   = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
      fa_x1_d = sel_x1;
      fa_x2_d = x2_eff;
    end
    // A bubble enters stage 0 whenever nothing is transferred.
    tag_vld_d = {tag_vld_q[LAT-1:0], xfer};
    tag_id_d  = {tag_id_q[LAT-1:0], gnt_idx};

    resp_valid_d = '0;
    resp_y_d     = resp_y_q;
    resp_ovf_d   = resp_ovf_q;
    if (tag_vld_q[LAT]) begin
      resp_valid_d = NREQ'(1) << tag_id_q[LAT];
      resp_y_d     = fa_y_i;
      resp_ovf_d   = fa_ovf_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr_q        <= '0;
      fa_x1_q      <= '0;
      fa_x2_q      <= '0;
      tag_vld_q    <= '0;
      tag_id_q     <= '0;
      resp_valid_q <= '0;
      resp_y_q     <= '0;
      resp_ovf_q   <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      fa_x1_q      <= fa_x1_d;
      fa_x2_q      <= fa_x2_d;
      tag_vld_q    <= tag_vld_d;
      tag_id_q     <= tag_id_d;
      resp_valid_q <= resp_valid_d;
      resp_y_q     <= resp_y_d;
      resp_ovf_q   <= resp_ovf_d;
    end
  end

  assign req_ready_o  = gnt;
  assign fa_x1_o      = fa_x1_q;
  assign fa_x2_o      = fa_x2_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_y_o     = resp_y_q;
  assign resp_ovf_o   = resp_ovf_q;
  assign busy_o       = (|tag_vld_q) | (|resp_valid_q);

endmodule
